// File: rtl/adder_pkg.sv
// adder_pkg: FSM state encodings and default sizing shared by the serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational W-bit adder slice with carry in/out.
module adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    assign {co, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};

endmodule

// File: rtl/adder_seq.sv
// adder_seq: multi-cycle add/subtract, CHUNK bits per clock through one shared slice.
// Define ADDER_SEQ_FLAGS_EN to add the zero and ovf result flags.
module adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             busy,
`ifdef ADDER_SEQ_FLAGS_EN
    output logic             zero,
    output logic             ovf,
`endif
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] op_a, op_b;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] sum;
    logic             co, last, accept;

    assign last   = idx == IW'(NCHUNK - 1);
    assign accept = state == IDLE && start;
    // The running carry doubles as the carry-out once the last chunk is in.
    assign c      = carry;

    adder_chunk #(.W(CHUNK)) u_chunk (
        .x  (op_a[idx*CHUNK +: CHUNK]),
        .y  (op_b[idx*CHUNK +: CHUNK]),
        .ci (carry),
        .sum(sum),
        .co (co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = accept                  ? RUN  :
                   (state == RUN && last)  ? DONE :
                   (state == DONE)         ? IDLE : state;
    end

    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            s     <= '0;
`ifdef ADDER_SEQ_FLAGS_EN
            zero  <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= sub | cin;
            idx   <= '0;
`ifdef ADDER_SEQ_FLAGS_EN
            zero  <= 1'b1;
`endif
        end else if (state == RUN) begin
            s[idx*CHUNK +: CHUNK] <= sum;
            carry <= co;
            idx   <= last ? '0 : idx + 1'b1;
`ifdef ADDER_SEQ_FLAGS_EN
            zero  <= zero & ~|sum;
            if (last) ovf <= op_a[WIDTH-1] == op_b[WIDTH-1] && sum[CHUNK-1] != op_a[WIDTH-1];
`endif
        end
    end

endmodule

// File: tb/tb_adder_seq.sv
// tb_adder_seq: randomized and directed checks of adder_seq against an arithmetic model.
module tb_adder_seq;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0, cin = 1'b0;
    logic [31:0] a = '0, b = '0, s0, s1;
    logic        c0, c1, busy0, busy1, done0, done1;
`ifdef ADDER_SEQ_FLAGS_EN
    logic        zero0, ovf0, zero1, ovf1;
`endif
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    adder_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .s(s0), .c(c0), .busy(busy0),
`ifdef ADDER_SEQ_FLAGS_EN
        .zero(zero0), .ovf(ovf0),
`endif
        .done(done0)
    );

    adder_seq #(.WIDTH(32), .CHUNK(32)) u_one (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .s(s1), .c(c1), .busy(busy1),
`ifdef ADDER_SEQ_FLAGS_EN
        .zero(zero1), .ovf(ovf1),
`endif
        .done(done1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; inj >= 0 re-asserts start (a=1,b=1) at that cycle of RUN.
    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                          input logic xc, input int inj);
        longint      ua, ub, sa, sb, sr;
        logic [31:0] es, s1c;
        logic        ec, ez, eo, c1c;
        int          cyc, bn, d1, extra;
        ua = xa;
        ub = xb;
        sa = $signed(xa);
        sb = $signed(xb);
        es = xs ? xa - xb : xa + xb + 32'(xc);
        ec = xs ? xa >= xb : (ua + ub + longint'(xc)) > 64'hFFFF_FFFF;
        sr = xs ? sa - sb : sa + sb + longint'(xc);
        eo = sr > 64'sd2147483647 || sr < -64'sd2147483648;
        ez = es == 0;
        a = xa; b = xb; sub = xs; cin = xc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
        cyc = 0; d1 = -1; bn = 0; s1c = '0; c1c = 1'b0;
        while (cyc < 20) begin
            if (done1 && d1 < 0) begin
                d1 = cyc; s1c = s1; c1c = c1;
            end
            if (done0) break;
            bn += int'(busy0);
            start = cyc == inj;
            if (cyc == inj) begin
                a = 1; b = 1; sub = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("latency", 64'(cyc), 4);
        check("busy_cycles", 64'(bn), 4);
        check("s", s0, es);
        check("c", c0, ec);
`ifdef ADDER_SEQ_FLAGS_EN
        check("zero", zero0, ez);
        check("ovf", ovf0, eo);
`endif
        check("one_chunk_latency", 64'(d1), 1);
        check("one_chunk_s", s1c, es);
        check("one_chunk_c", c1c, ec);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            extra += int'(done0);
        end
        check("single_done", 64'(extra), 0);
        check("s_held", s0, es);
    endtask

    initial begin
        int extra;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s", s0, 0);
        check("rst_c", c0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        rst_n = 1'b1;
        run_op(32'd8, 32'd80, 1'b0, 1'b0, -1);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, -1);
        run_op(32'd5, 32'd7, 1'b1, 1'b0, -1);
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, -1);
        run_op(32'd80, 32'd80, 1'b0, 1'b0, 1);
        run_op(32'h8000_0000, 32'd1, 1'b1, 1'b1, -1);
        // Abort after two RUN edges with a one-cycle reset pulse.
        a = 32'h0000_0100; b = 32'h0000_0200; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_s", s0, 0);
        check("abort_c", c0, 0);
        check("abort_busy", busy0, 0);
        check("abort_done", done0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            extra += int'(done0);
        end
        check("abort_no_done", 64'(extra), 0);
        run_op(32'd208, 32'd308, 1'b0, 1'b0, -1);
        for (int i = 0; i < 24; i++)
            run_op($urandom, (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                   1'($urandom), 1'($urandom), -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adder_seq.md
ADDER_SEQ -- requirements
Module: adder_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and sum width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 sub  input  1  0 = add, 1 = subtract; latched with start.
REQ-007 a, b  input  WIDTH  operands; latched with start.
REQ-008 cin  input  1  carry-in for add; ignored when sub=1.
REQ-009 s  output  WIDTH  result; holds its value until the next accepted start.
REQ-010 c  output  1  carry out of MSB; for sub, 1 = no borrow.
REQ-011 busy  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse when s and c become valid.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 In IDLE, start=1 at an edge SHALL latch a, b^{WIDTH{sub}}, carry = sub ? 1 : cin, clear the chunk index, and go to RUN.
REQ-015 Each RUN edge SHALL add chunk i of both operands plus the running carry, write chunk i of s, update the carry, and increment i.
REQ-016 After NCHUNK = WIDTH/CHUNK RUN edges the FSM SHALL go to DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-017 Latency: start sampled at edge E SHALL give done=1 in the cycle after edge E+NCHUNK (defaults: E+4).
REQ-018 CHUNK=WIDTH SHALL give a single RUN cycle (done after edge E+1).
REQ-019 start during RUN or DONE SHALL be ignored; no queueing.
REQ-020 Result SHALL wrap modulo 2^WIDTH, with c carrying the lost bit.
REQ-021 s SHALL be partially updated during RUN; only values present while done=1 and afterwards are valid.

Reset
REQ-022 rst_n low SHALL immediately force IDLE and clear s, c, busy, done, the chunk index and all latched operands, including mid-RUN (the operation is aborted; done does not pulse).
REQ-023 After rst_n releases, the first start SHALL be accepted at the next rising edge.

Configuration
REQ-024 Macro ADDER_SEQ_FLAGS_EN defined: add outputs zero (s==0) and ovf (two's-complement signed overflow), both WIDTH-independent 1-bit, valid with done, held like s, and reset to 0.
REQ-025 Macro not defined: zero and ovf ports and logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-026 Shared package adder_pkg SHALL hold the FSM state encodings (IDLE, RUN, DONE) and the default WIDTH/CHUNK constants.
REQ-027 One sub-module, adder_chunk: combinational CHUNK-bit adder (x, y, ci -> sum, co), instantiated once and muxed by the chunk index.

Verification (defaults WIDTH=32, CHUNK=8)
REQ-028 a=8, b=80, cin=0, sub=0, start pulse -> done 4 edges later, s=88, c=0, busy high for exactly 4 cycles.
REQ-029 a=0xFFFFFFFF, b=1, cin=0 -> s=0, c=1; with ADDER_SEQ_FLAGS_EN: zero=1, ovf=0.
REQ-030 a=5, b=7, sub=1 -> s=0xFFFFFFFE, c=0; a=0x7FFFFFFF, b=1, add -> s=0x80000000, ovf=1.
REQ-031 start re-asserted with a=1, b=1 during RUN of a=80, b=80 -> single done, s=160; second request ignored.
REQ-032 rst_n low for 1 cycle after 2 RUN edges -> s=0, busy=0, no done pulse; next start of a=208, b=308 -> s=516, c=0.
